// File: rtl/tbird_pkg.sv
// Shared defaults, channel indices and helpers for the Thunderbird input
// conditioning stage.
package tbird_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF   = 5;

  localparam int NUM_CH  = 3;
  localparam int CH_IZQ  = 0;
  localparam int CH_DER  = 1;
  localparam int CH_EMER = 2;

  function automatic int deb_cnt_w(input int deb_cycles);
    int w;
    w = $clog2(deb_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tick_cnt_w(input int tick_div);
    int w;
    w = $clog2(tick_div);
    return (w < 1) ? 1 : w;
  endfunction

  // Left+right together is treated as a hazard request, so the three
  // command bits can never be high at the same time.
  function automatic logic [NUM_CH-1:0] resolve(input logic [NUM_CH-1:0] st);
    logic [NUM_CH-1:0] cmd;
    cmd[CH_EMER] = st[CH_EMER] | (st[CH_IZQ] & st[CH_DER]);
    cmd[CH_IZQ]  = st[CH_IZQ] & ~cmd[CH_EMER];
    cmd[CH_DER]  = st[CH_DER] & ~cmd[CH_EMER];
    return cmd;
  endfunction

endpackage

// File: rtl/tbird_debounce.sv
// One switch channel: two-flop synchronizer followed by a stable-level
// debouncer that needs DEB_CYCLES consecutive differing samples to flip.
module tbird_debounce
  import tbird_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic st,
  output logic st_next
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          st_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    st_next  = st_reg;
    cnt_next = '0;
    if (s2_reg != st_reg) begin
      if (cnt_reg == CNT_LAST) begin
        st_next = s2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      st_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg  <= raw;
      s2_reg  <= s1_reg;
      st_reg  <= st_next;
      cnt_reg <= cnt_next;
    end
  end

  assign st = st_reg;

endmodule

// File: rtl/tbird_input_cond.sv
// Conditions the raw turn/hazard switches into exclusive IZQ/DER/EMER
// requests and generates the blink step enable TICK.
module tbird_input_cond
  import tbird_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic IZQ_RAW,
  input  logic DER_RAW,
  input  logic EMER_RAW,
  output logic IZQ,
  output logic DER,
  output logic EMER,
  output logic TICK
);

  localparam int DW = tick_cnt_w(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] st_vec;
  logic [NUM_CH-1:0] st_next_vec;
  logic [NUM_CH-1:0] cmd;
  logic [NUM_CH-1:0] cmd_next;
  logic [DW-1:0]     div_reg;

  assign raw_vec[CH_IZQ]  = IZQ_RAW;
  assign raw_vec[CH_DER]  = DER_RAW;
  assign raw_vec[CH_EMER] = EMER_RAW;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tbird_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (CLOCK),
        .srst   (RESET),
        .raw    (raw_vec[gi]),
        .st     (st_vec[gi]),
        .st_next(st_next_vec[gi])
      );
    end
  endgenerate

  assign cmd      = resolve(st_vec);
  assign cmd_next = resolve(st_next_vec);

  // Comparing against the upcoming command clears the divider on the very
  // edge the new command is registered, so its first step is a full period out.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_reg <= '0;
    end else if (cmd_next != cmd) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign IZQ  = cmd[CH_IZQ];
  assign DER  = cmd[CH_DER];
  assign EMER = cmd[CH_EMER];
  assign TICK = (div_reg == DIV_LAST);

endmodule

// File: tb/tb_tbird_input_cond.sv
// Self-checking bench for tbird_input_cond: directed scenarios plus a random
// run, all compared against a sample-window reference model.
module tb_tbird_input_cond;

  localparam int DEB  = 4;
  localparam int TDIV = 5;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic IZQ_RAW = 1'b0;
  logic DER_RAW = 1'b0;
  logic EMER_RAW = 1'b0;
  logic IZQ, DER, EMER, TICK;

  int n_cmp  = 0;
  int n_fail = 0;

  tbird_input_cond #(
    .DEB_CYCLES(DEB),
    .TICK_DIV  (TDIV)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .IZQ_RAW (IZQ_RAW),
    .DER_RAW (DER_RAW),
    .EMER_RAW(EMER_RAW),
    .IZQ     (IZQ),
    .DER     (DER),
    .EMER    (EMER),
    .TICK    (TICK)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: a level flips once the last DEB synchronized samples
  // (raw taken two edges earlier) all disagree with it.
  logic [DEB+1:0] m_hist [3];
  logic [2:0]     m_st;
  logic [2:0]     m_raw;
  logic           m_izq, m_der, m_emer;
  logic           n_izq, n_der, n_emer;
  int             m_phase;
  logic [DEB-1:0] m_win;

  always @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_st = '0;
      m_izq = 0; m_der = 0; m_emer = 0;
      m_phase = 0;
    end else begin
      m_raw = {EMER_RAW, DER_RAW, IZQ_RAW};
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][DEB:0], m_raw[i]};
        m_win = m_hist[i][DEB+1:2];
        if (m_st[i] ? (m_win == '0) : (&m_win)) m_st[i] = ~m_st[i];
      end
      if (m_st[2] || (m_st[0] && m_st[1])) begin
        n_emer = 1; n_izq = 0; n_der = 0;
      end else begin
        n_emer = 0; n_izq = m_st[0]; n_der = m_st[1];
      end
      if ({n_izq, n_der, n_emer} != {m_izq, m_der, m_emer}) m_phase = 0;
      else m_phase = (m_phase + 1) % TDIV;
      m_izq = n_izq; m_der = n_der; m_emer = n_emer;
    end
  end

  wire [3:0] m_out = {m_izq, m_der, m_emer, (m_phase == TDIV - 1)};

  task automatic apply_reset();
    @(negedge CLOCK);
    RESET = 1; IZQ_RAW = 0; DER_RAW = 0; EMER_RAW = 0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 0;
  endtask

  task automatic test_reset();
    @(negedge CLOCK);
    RESET = 1; IZQ_RAW = 0; DER_RAW = 0; EMER_RAW = 0;
    @(posedge CLOCK); #1;
    n_cmp++;
    if ({IZQ, DER, EMER, TICK} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0000", {IZQ, DER, EMER, TICK});
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLOCK); RESET = 0;
      @(posedge CLOCK); #1;
      n_cmp++;
      if ({IZQ, DER, EMER, TICK} !== {3'b000, (k % TDIV == TDIV - 1)}) begin
        n_fail++;
        $display("FAIL reset_tick k=%0d: got %b expected %b", k, {IZQ, DER, EMER, TICK},
                 {3'b000, (k % TDIV == TDIV - 1)});
      end
    end
    $display("test_reset done: %0d compared", n_cmp);
  endtask

  task automatic test_izq_hold();
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLOCK); IZQ_RAW = 1;
      @(posedge CLOCK); #1;
      n_cmp++;
      if ({IZQ, DER, EMER} !== {(k >= 6), 2'b00} || (k >= 6 && TICK !== (k == 10))) begin
        n_fail++;
        $display("FAIL izq_hold k=%0d: got %b tick=%b expected %b tick=%b", k, {IZQ, DER, EMER},
                 TICK, {(k >= 6), 2'b00}, (k == 10));
      end
      n_cmp++;
      if ({IZQ, DER, EMER, TICK} !== m_out) begin
        n_fail++;
        $display("FAIL izq_hold_model k=%0d: got %b expected %b", k, {IZQ, DER, EMER, TICK}, m_out);
      end
    end
    $display("test_izq_hold done: %0d compared", n_cmp);
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLOCK); IZQ_RAW = (k <= 3);
      @(posedge CLOCK); #1;
      n_cmp++;
      if (IZQ !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch3 k=%0d: got IZQ=%b expected 0", k, IZQ);
      end
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLOCK); IZQ_RAW = (k <= 5);
      @(posedge CLOCK); #1;
      n_cmp++;
      if (IZQ !== (k >= 6 && k <= 10) || {IZQ, DER, EMER, TICK} !== m_out) begin
        n_fail++;
        $display("FAIL pulse5 k=%0d: got %b expected izq=%b model=%b", k, {IZQ, DER, EMER, TICK},
                 (k >= 6 && k <= 10), m_out);
      end
    end
    $display("test_glitch done: %0d compared", n_cmp);
  endtask

  task automatic test_izq_der();
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK); IZQ_RAW = 1; DER_RAW = (k >= 10);
      @(posedge CLOCK); #1;
      n_cmp++;
      if ({IZQ, DER, EMER} !== {(k >= 6 && k < 15), 1'b0, (k >= 15)} ||
          {IZQ, DER, EMER, TICK} !== m_out) begin
        n_fail++;
        $display("FAIL izq_der k=%0d: got %b expected %b model=%b", k, {IZQ, DER, EMER},
                 {(k >= 6 && k < 15), 1'b0, (k >= 15)}, m_out);
      end
    end
    $display("test_izq_der done: %0d compared", n_cmp);
  endtask

  task automatic test_emer_over_izq();
    logic [2:0] exp;
    apply_reset();
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLOCK); IZQ_RAW = 1; EMER_RAW = (k >= 10 && k < 20);
      @(posedge CLOCK); #1;
      exp = {((k >= 6 && k < 15) || k >= 25), 1'b0, (k >= 15 && k < 25)};
      n_cmp++;
      if ({IZQ, DER, EMER} !== exp || (k >= 25 && TICK !== (k == 29)) ||
          {IZQ, DER, EMER, TICK} !== m_out) begin
        n_fail++;
        $display("FAIL emer_over_izq k=%0d: got %b tick=%b expected %b model=%b", k,
                 {IZQ, DER, EMER}, TICK, exp, m_out);
      end
    end
    $display("test_emer_over_izq done: %0d compared", n_cmp);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLOCK); IZQ_RAW = 1; RESET = (k == 5);
      @(posedge CLOCK); #1;
      n_cmp++;
      if ({IZQ, DER, EMER} !== {(k >= 11), 2'b00} || (k == 5 && TICK !== 1'b0) ||
          {IZQ, DER, EMER, TICK} !== m_out) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got %b expected %b model=%b", k,
                 {IZQ, DER, EMER, TICK}, {(k >= 11), 2'b00}, m_out);
      end
    end
    $display("test_reset_mid done: %0d compared", n_cmp);
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge CLOCK);
      if ($urandom_range(0, 5) == 0) IZQ_RAW  = ~IZQ_RAW;
      if ($urandom_range(0, 5) == 0) DER_RAW  = ~DER_RAW;
      if ($urandom_range(0, 7) == 0) EMER_RAW = ~EMER_RAW;
      RESET = ($urandom_range(0, 199) == 0);
      @(posedge CLOCK); #1;
      n_cmp++;
      if ({IZQ, DER, EMER, TICK} !== m_out || (IZQ + DER + EMER) > 1) begin
        n_fail++;
        $display("FAIL random k=%0d: got %b expected %b", k, {IZQ, DER, EMER, TICK}, m_out);
      end
    end
    RESET = 0;
    $display("test_random done: %0d compared", n_cmp);
  endtask

  initial begin
    test_reset();
    test_izq_hold();
    test_glitch();
    test_izq_der();
    test_emer_over_izq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
